serial_ripple_subtractor: RTL and testbench

Bit-serial subtractor, the inverse operation of the team's 4-bit ripple-carry adder. It computes D = A - B - Bin one bit per clock through a single full-subtractor cell, LSB first, and uses a start/busy/done handshake. It sits beside the ripple adder in the datapath lab library and trades area (one cell instead of WIDTH cells) for WIDTH cycles of latency.

---
 rtl/serial_ripple_subtractor.sv | 130 +++++++++++++
 tb/tb_serial_ripple_subtractor.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_ripple_subtractor.sv
// Bit-serial subtractor: one full-subtractor cell computes D = A - B - Bin,
// LSB first, over WIDTH clocks with a start/busy/done handshake.
module serial_ripple_subtractor #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Bin,
    output logic [WIDTH-1:0] D,
    output logic             Bout,
    output logic             busy,
    output logic             done
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] r_sh;
    logic             br;
    logic [CW-1:0]    cnt;

    logic             accept;
    logic             last;
    logic             a0;
    logic             b0;
    logic             d_bit;
    logic             br_next;
    logic [WIDTH-1:0] r_next;

    // Single full-subtractor cell working on the current LSBs
    always_comb begin
        a0      = a_sh[0];
        b0      = b_sh[0];
        d_bit   = a0 ^ b0 ^ br;
        br_next = (~a0 & b0) | (~(a0 ^ b0) & br);
        r_next  = {d_bit, r_sh[WIDTH-1:1]};
        accept  = start && ((state == IDLE) || (state == DONE));
        last    = (state == RUN) && (cnt == LAST_CNT);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                if (last) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = accept ? RUN : IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Operand shifters, borrow flop and bit counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh <= '0;
            b_sh <= '0;
            r_sh <= '0;
            br   <= 1'b0;
            cnt  <= '0;
        end else if (accept) begin
            a_sh <= A;
            b_sh <= B;
            r_sh <= '0;
            br   <= Bin;
            cnt  <= '0;
        end else if (state == RUN) begin
            a_sh <= a_sh >> 1;
            b_sh <= b_sh >> 1;
            r_sh <= r_next;
            br   <= br_next;
            if (!last) begin
                cnt <= cnt + CW'(1);
            end
        end
    end

    // Result registers only move on the completion edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            D    <= '0;
            Bout <= 1'b0;
            busy <= 1'b0;
            done <= 1'b0;
        end else begin
            done <= last;
            if (last) begin
                D    <= r_next;
                Bout <= br_next;
            end
            if (accept) begin
                busy <= 1'b1;
            end else if (last) begin
                busy <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_serial_ripple_subtractor.sv
// Self-checking bench for serial_ripple_subtractor: directed plan vectors,
// handshake corner cases, async reset, exhaustive and random checks.
module tb_serial_ripple_subtractor;

    localparam int W = 4;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic         Bin;
    logic [W-1:0] D;
    logic         Bout;
    logic         busy;
    logic         done;

    int passed;
    int total;

    serial_ripple_subtractor #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .A     (A),
        .B     (B),
        .Bin   (Bin),
        .D     (D),
        .Bout  (Bout),
        .busy  (busy),
        .done  (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: plain integer subtraction, {Bout,D} = (a-b-bin) mod 2^(W+1)
    function automatic logic [W:0] model(input int a, input int b, input int bin);
        int diff;
        diff = a - b - bin;
        return diff[W:0];
    endfunction

    // Drives one request and waits (bounded) for done; no checking here
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin,
                          output int lat, output int busy_cnt,
                          output logic [W-1:0] d_early, output logic [W-1:0] d,
                          output logic bo);
        @(negedge clk);
        A = a; B = b; Bin = bin; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        d_early = D;
        busy_cnt = busy ? 1 : 0;
        lat = -1;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk);
            #1;
            if (done) begin
                lat = i;
                break;
            end
            if (busy) busy_cnt++;
        end
        d = D;
        bo = Bout;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; A = '0; B = '0; Bin = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        total++;
        if ({D, Bout, busy, done} !== '0)
            $display("[TB] FAIL reset_outputs actual=%b required=%b", {D, Bout, busy, done}, 7'b0);
        else passed++;
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        total++;
        if ({D, Bout, busy, done} !== '0)
            $display("[TB] FAIL idle_after_reset actual=%b required=%b", {D, Bout, busy, done}, 7'b0);
        else passed++;
    endtask

    task automatic test_directed();
        logic [W-1:0] ta [7] = '{4'd5, 4'd3, 4'd0, 4'd15, 4'd7, 4'd15, 4'd0};
        logic [W-1:0] tb [7] = '{4'd3, 4'd5, 4'd0, 4'd15, 4'd7, 4'd0, 4'd15};
        logic         tc [7] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        logic [W-1:0] td [7] = '{4'd2, 4'd14, 4'd15, 4'd15, 4'd0, 4'd14, 4'd1};
        logic         te [7] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        logic [W-1:0] prev_d;
        int lat, bc;
        logic [W-1:0] de, d;
        logic bo;
        prev_d = D;
        for (int i = 0; i < 7; i++) begin
            run_op(ta[i], tb[i], tc[i], lat, bc, de, d, bo);
            total++;
            if (lat !== W) $display("[TB] FAIL latency[%0d] actual=%0d required=%0d", i, lat, W);
            else passed++;
            total++;
            if (bc !== W) $display("[TB] FAIL busy_cycles[%0d] actual=%0d required=%0d", i, bc, W);
            else passed++;
            total++;
            if (de !== prev_d) $display("[TB] FAIL d_hold[%0d] actual=%0d required=%0d", i, de, prev_d);
            else passed++;
            total++;
            if ({bo, d} !== {te[i], td[i]})
                $display("[TB] FAIL directed[%0d] actual Bout=%0b D=%0d required Bout=%0b D=%0d",
                         i, bo, d, te[i], td[i]);
            else passed++;
            prev_d = td[i];
            @(posedge clk);
            #1;
            total++;
            if (done !== 1'b0) $display("[TB] FAIL done_pulse_width[%0d] actual=%b required=0", i, done);
            else passed++;
        end
    endtask

    task automatic test_ignore_start();
        int dones;
        logic [W-1:0] d_seen;
        logic bo_seen;
        dones = 0; d_seen = '0; bo_seen = 1'b0;
        @(negedge clk);
        A = 4'd9; B = 4'd4; Bin = 1'b0; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int i = 1; i <= 12; i++) begin
            A = W'($urandom); B = W'($urandom); Bin = 1'($urandom);
            if (i == 2) begin
                A = 4'd1; B = 4'd1; start = 1'b1;
            end else begin
                start = 1'b0;
            end
            @(posedge clk);
            #1;
            if (done) begin
                dones++;
                d_seen = D;
                bo_seen = Bout;
            end
        end
        start = 1'b0;
        total++;
        if (dones !== 1) $display("[TB] FAIL ignore_start_dones actual=%0d required=1", dones);
        else passed++;
        total++;
        if ({bo_seen, d_seen} !== {1'b0, 4'd5})
            $display("[TB] FAIL ignore_start_result actual Bout=%0b D=%0d required Bout=0 D=5", bo_seen, d_seen);
        else passed++;
    endtask

    task automatic test_back_to_back();
        int first, second;
        first = -1; second = -1;
        @(negedge clk);
        A = 4'd12; B = 4'd5; Bin = 1'b0; start = 1'b1;
        @(posedge clk);
        #1;
        A = 4'd2; B = 4'd6;
        for (int c = 1; c <= 30; c++) begin
            @(posedge clk);
            #1;
            if (first >= 0 && c == first + 1) start = 1'b0;
            if (done && first < 0) begin
                first = c;
                total++;
                if ({Bout, D} !== {1'b0, 4'd7})
                    $display("[TB] FAIL b2b_first actual Bout=%0b D=%0d required Bout=0 D=7", Bout, D);
                else passed++;
            end else if (done && first >= 0) begin
                second = c;
                total++;
                if ({Bout, D} !== {1'b1, 4'd12})
                    $display("[TB] FAIL b2b_second actual Bout=%0b D=%0d required Bout=1 D=12", Bout, D);
                else passed++;
                break;
            end
        end
        start = 1'b0;
        total++;
        if (first < 0 || second - first !== W + 1)
            $display("[TB] FAIL b2b_spacing actual=%0d required=%0d", second - first, W + 1);
        else passed++;
    endtask

    task automatic test_async_reset();
        int dones, lat, bc;
        logic [W-1:0] de, d;
        logic bo;
        dones = 0;
        @(negedge clk);
        A = 4'd10; B = 4'd3; Bin = 1'b0; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if ({D, Bout, busy, done} !== '0)
            $display("[TB] FAIL async_reset_outputs actual=%b required=%b", {D, Bout, busy, done}, 7'b0);
        else passed++;
        #2;
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            if (done) dones++;
        end
        total++;
        if (dones !== 0) $display("[TB] FAIL async_reset_no_done actual=%0d required=0", dones);
        else passed++;
        total++;
        if ({D, Bout} !== '0) $display("[TB] FAIL async_reset_hold actual=%b required=0", {D, Bout});
        else passed++;
        run_op(4'd6, 4'd9, 1'b1, lat, bc, de, d, bo);
        total++;
        if (lat !== W || {bo, d} !== model(6, 9, 1))
            $display("[TB] FAIL after_reset_op actual lat=%0d {Bout,D}=%b required lat=%0d {Bout,D}=%b",
                     lat, {bo, d}, W, model(6, 9, 1));
        else passed++;
    endtask

    task automatic test_exhaustive();
        int lat, bc;
        logic [W-1:0] de, d;
        logic bo;
        logic [W:0] exp;
        for (int a = 0; a < (1 << W); a++)
            for (int b = 0; b < (1 << W); b++)
                for (int c = 0; c < 2; c++) begin
                    run_op(W'(a), W'(b), 1'(c), lat, bc, de, d, bo);
                    exp = model(a, b, c);
                    total++;
                    if (lat !== W || {bo, d} !== exp)
                        $display("[TB] FAIL exhaustive a=%0d b=%0d bin=%0d actual lat=%0d {Bout,D}=%b required lat=%0d {Bout,D}=%b",
                                 a, b, c, lat, {bo, d}, W, exp);
                    else passed++;
                    total++;
                    if (bo !== (a < b + c))
                        $display("[TB] FAIL exhaustive_borrow a=%0d b=%0d bin=%0d actual=%0b required=%0b",
                                 a, b, c, bo, (a < b + c));
                    else passed++;
                end
    endtask

    task automatic test_random();
        int lat, bc, a, b, c;
        logic [W-1:0] de, d;
        logic bo;
        for (int i = 0; i < 40; i++) begin
            a = int'($urandom_range((1 << W) - 1, 0));
            b = int'($urandom_range((1 << W) - 1, 0));
            c = int'($urandom_range(1, 0));
            run_op(W'(a), W'(b), 1'(c), lat, bc, de, d, bo);
            total++;
            if (lat !== W || bc !== W || {bo, d} !== model(a, b, c))
                $display("[TB] FAIL random a=%0d b=%0d bin=%0d actual lat=%0d busy=%0d {Bout,D}=%b required %0d %0d %b",
                         a, b, c, lat, bc, {bo, d}, W, W, model(a, b, c));
            else passed++;
            repeat (int'($urandom_range(2, 0))) @(posedge clk);
        end
    endtask

    initial begin
        passed = 0;
        total = 0;
        test_reset();
        test_directed();
        test_ignore_start();
        test_back_to_back();
        test_async_reset();
        test_exhaustive();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
